// File: rtl/pipe_pkg.sv
// Shared fetch/decode pipeline definitions: default widths, the bubble
// instruction, IF/ID buffer state encoding and instruction field decode.
package pipe_pkg;

  localparam int          INSTR_W_DFLT   = 16;
  localparam int          PC_W_DFLT      = 16;
  localparam logic [15:0] NOP_INSTR_DFLT = 16'h0000;

  // Encoding doubles as the occupancy count.
  localparam logic [1:0] ST_EMPTY = 2'd0;
  localparam logic [1:0] ST_ONE   = 2'd1;
  localparam logic [1:0] ST_FULL  = 2'd2;

  typedef struct packed {
    logic [3:0] opcode;
    logic [3:0] rd;
    logic [3:0] rs;
    logic [3:0] rt;
  } instr_fields_t;

  function automatic instr_fields_t decode_fields(input logic [15:0] instr);
    return instr_fields_t'(instr);
  endfunction

endpackage

// File: rtl/pipe_slot.sv
// One IF/ID buffer entry: load-enabled instruction + PC register with
// asynchronous clear.
module pipe_slot
  import pipe_pkg::*;
#(
  parameter int INSTR_W = INSTR_W_DFLT,
  parameter int PC_W    = PC_W_DFLT
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               load,
  input  logic [INSTR_W-1:0] load_instruction,
  input  logic [PC_W-1:0]    load_pc,
  output logic [INSTR_W-1:0] instruction,
  output logic [PC_W-1:0]    next_pc
);

  // NOTE: sequential state uses non-blocking assignments; the slot is small
  // enough that clearing it on reset costs nothing and keeps it X-free.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      instruction <= '0;
      next_pc     <= '0;
    end else if (load) begin
      instruction <= load_instruction;
      next_pc     <= load_pc;
    end
  end

endmodule

// File: rtl/if_id_buffer.sv
// Two-entry in-order skid buffer between fetch and decode. in_ready depends
// only on registered state, so there is no out_ready -> in_ready path.
module if_id_buffer
  import pipe_pkg::*;
#(
  parameter int                 INSTR_W   = INSTR_W_DFLT,
  parameter int                 PC_W      = PC_W_DFLT,
  parameter logic [INSTR_W-1:0] NOP_INSTR = NOP_INSTR_DFLT
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [INSTR_W-1:0] in_instruction,
  input  logic [PC_W-1:0]    in_next_pc,
  input  logic               flush,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [INSTR_W-1:0] out_instruction,
  output logic [PC_W-1:0]    out_next_pc,
  output logic [3:0]         out_opcode,
  output logic [3:0]         out_rd,
  output logic [3:0]         out_rs,
  output logic [3:0]         out_rt,
  output logic [1:0]         occupancy
);

  logic [1:0]         state;
  logic [1:0]         state_next;
  logic               push;
  logic               pop;
  logic               head_load;
  logic               head_from_tail;
  logic               tail_load;
  logic [INSTR_W-1:0] head_instr;
  logic [PC_W-1:0]    head_pc;
  logic [INSTR_W-1:0] tail_instr;
  logic [PC_W-1:0]    tail_pc;
  logic [INSTR_W-1:0] head_src_instr;
  logic [PC_W-1:0]    head_src_pc;
  instr_fields_t      fields;

  assign in_ready  = (state != ST_FULL);
  assign out_valid = (state != ST_EMPTY);
  assign occupancy = state;
  assign push      = in_valid & in_ready;
  assign pop       = out_valid & out_ready;

  // NOTE: every always_comb output gets a default first so no latch is inferred.
  always_comb begin
    state_next     = state;
    head_load      = 1'b0;
    head_from_tail = 1'b0;
    tail_load      = 1'b0;
    if (flush) begin
      state_next = ST_EMPTY;
    end else begin
      case (state)
        ST_EMPTY: if (push) begin
          state_next = ST_ONE;
          head_load  = 1'b1;
        end
        ST_ONE: begin
          case ({push, pop})
            2'b10: begin
              state_next = ST_FULL;
              tail_load  = 1'b1;
            end
            2'b01: state_next = ST_EMPTY;
            2'b11: head_load  = 1'b1;  // head consumed, incoming takes its place
            default: ;
          endcase
        end
        ST_FULL: if (pop) begin
          state_next     = ST_ONE;
          head_load      = 1'b1;
          head_from_tail = 1'b1;
        end
        default: state_next = ST_EMPTY;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_EMPTY;
    else        state <= state_next;
  end

  assign head_src_instr = head_from_tail ? tail_instr : in_instruction;
  assign head_src_pc    = head_from_tail ? tail_pc    : in_next_pc;

  pipe_slot #(.INSTR_W(INSTR_W), .PC_W(PC_W)) u_head (
    .clk              (clk),
    .rst_n            (rst_n),
    .load             (head_load),
    .load_instruction (head_src_instr),
    .load_pc          (head_src_pc),
    .instruction      (head_instr),
    .next_pc          (head_pc)
  );

  pipe_slot #(.INSTR_W(INSTR_W), .PC_W(PC_W)) u_tail (
    .clk              (clk),
    .rst_n            (rst_n),
    .load             (tail_load),
    .load_instruction (in_instruction),
    .load_pc          (in_next_pc),
    .instruction      (tail_instr),
    .next_pc          (tail_pc)
  );

  // Stale slot contents stay hidden behind the bubble while empty.
  assign out_instruction = out_valid ? head_instr : NOP_INSTR;
  assign out_next_pc     = out_valid ? head_pc    : '0;

  assign fields     = decode_fields(out_instruction[15:0]);
  assign out_opcode = fields.opcode;
  assign out_rd     = fields.rd;
  assign out_rs     = fields.rs;
  assign out_rt     = fields.rt;

endmodule

// File: tb/tb_if_id_buffer.sv
// Directed and scoreboard-driven checks for the IF/ID skid buffer.
module tb_if_id_buffer;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] in_instruction;
  logic [15:0] in_next_pc;
  logic        flush;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] out_instruction;
  logic [15:0] out_next_pc;
  logic [3:0]  out_opcode;
  logic [3:0]  out_rd;
  logic [3:0]  out_rs;
  logic [3:0]  out_rt;
  logic [1:0]  occupancy;

  int n_checks = 0;
  int n_pass   = 0;

  if_id_buffer dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .in_valid        (in_valid),
    .in_ready        (in_ready),
    .in_instruction  (in_instruction),
    .in_next_pc      (in_next_pc),
    .flush           (flush),
    .out_valid       (out_valid),
    .out_ready       (out_ready),
    .out_instruction (out_instruction),
    .out_next_pc     (out_next_pc),
    .out_opcode      (out_opcode),
    .out_rd          (out_rd),
    .out_rs          (out_rs),
    .out_rt          (out_rt),
    .occupancy       (occupancy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s got %h expected %h", tag, got, exp);
  endtask

  // Advance one edge and settle 1 time unit after it.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [15:0] instr, input logic [15:0] pc,
                       input logic rdy, input logic fl);
    in_valid       = v;
    in_instruction = instr;
    in_next_pc     = pc;
    out_ready      = rdy;
    flush          = fl;
  endtask

  typedef struct packed {
    logic [15:0] instr;
    logic [15:0] pc;
  } entry_t;

  entry_t sb[$];

  initial begin
    rst_n = 1'b0;
    drive(1'b0, 16'h0, 16'h0, 1'b0, 1'b0);

    // Reset state, sampled while reset is held.
    #12;
    check("rst_valid", out_valid, 0);
    check("rst_occ", occupancy, 0);
    check("rst_instr", out_instruction, 16'h0000);
    check("rst_pc", out_next_pc, 0);
    rst_n = 1'b1;
    #1;
    check("rst_in_ready", in_ready, 1);

    // Basic flow.
    drive(1'b1, 16'h1234, 16'h0001, 1'b1, 1'b0);
    check("basic_pre_valid", out_valid, 0);
    step();
    drive(1'b0, 16'h0, 16'h0, 1'b1, 1'b0);
    check("basic_valid", out_valid, 1);
    check("basic_instr", out_instruction, 16'h1234);
    check("basic_pc", out_next_pc, 16'h0001);
    check("basic_opcode", out_opcode, 4'h1);
    check("basic_rd", out_rd, 4'h2);
    check("basic_rs", out_rs, 4'h3);
    check("basic_rt", out_rt, 4'h4);
    step();
    check("basic_drain_occ", occupancy, 0);
    check("basic_drain_nop", out_instruction, 16'h0000);

    // Fill under backpressure.
    drive(1'b1, 16'hA001, 16'h0011, 1'b0, 1'b0);
    step();
    check("fill_one_occ", occupancy, 1);
    drive(1'b1, 16'hB002, 16'h0012, 1'b0, 1'b0);
    step();
    drive(1'b0, 16'h0, 16'h0, 1'b0, 1'b0);
    check("fill_occ", occupancy, 2);
    check("fill_in_ready", in_ready, 0);
    check("fill_head", out_instruction, 16'hA001);
    step();
    check("fill_hold_head", out_instruction, 16'hA001);
    check("fill_hold_pc", out_next_pc, 16'h0011);
    out_ready = 1'b1;
    check("drain_a", out_instruction, 16'hA001);
    step();
    check("drain_b", out_instruction, 16'hB002);
    check("drain_b_pc", out_next_pc, 16'h0012);
    check("drain_b_occ", occupancy, 1);
    step();
    check("drain_empty", out_valid, 0);

    // Streaming: one in, one out each cycle.
    for (int k = 1; k <= 10; k++) begin
      drive(1'b1, 16'h5000 + 16'(k), 16'(k), 1'b1, 1'b0);
      step();
      check($sformatf("stream_pc_%0d", k), out_next_pc, k);
      check($sformatf("stream_occ_%0d", k), occupancy, 1);
    end
    drive(1'b0, 16'h0, 16'h0, 1'b1, 1'b0);
    step();
    check("stream_drain", occupancy, 0);

    // Flush while full with a same-cycle push and pop.
    drive(1'b1, 16'hD001, 16'h0021, 1'b0, 1'b0);
    step();
    drive(1'b1, 16'hD002, 16'h0022, 1'b0, 1'b0);
    step();
    check("flush_pre_occ", occupancy, 2);
    drive(1'b1, 16'hC003, 16'h0023, 1'b1, 1'b1);
    step();
    drive(1'b0, 16'h0, 16'h0, 1'b1, 1'b0);
    check("flush_occ", occupancy, 0);
    check("flush_instr", out_instruction, 16'h0000);
    check("flush_valid", out_valid, 0);
    step();
    check("flush_no_c003", out_valid, 0);
    drive(1'b1, 16'hE004, 16'h0024, 1'b0, 1'b0);
    step();
    check("flush_next_head", out_instruction, 16'hE004);

    // Asynchronous reset mid-cycle while holding one entry.
    drive(1'b0, 16'h0, 16'h0, 1'b0, 1'b0);
    check("arst_pre_occ", occupancy, 1);
    #2 rst_n = 1'b0;
    #1;
    check("arst_valid", out_valid, 0);
    check("arst_occ", occupancy, 0);
    check("arst_instr", out_instruction, 16'h0000);
    check("arst_pc", out_next_pc, 0);
    #2 rst_n = 1'b1;
    #1;
    check("arst_in_ready", in_ready, 1);
    step();
    check("arst_stays_empty", out_valid, 0);

    // Random stress against a queue scoreboard.
    for (int cyc = 0; cyc < 10000; cyc++) begin
      logic   v, r, f;
      entry_t exp_head;
      entry_t nxt;
      v = ($urandom_range(0, 3) != 0);
      r = ($urandom_range(0, 2) != 0);
      f = ($urandom_range(0, 40) == 0);
      nxt.instr = 16'($urandom);
      nxt.pc    = 16'(cyc);
      drive(v, nxt.instr, nxt.pc, r, f);
      #1;
      exp_head = (sb.size() > 0) ? sb[0] : '{instr: 16'h0000, pc: 16'h0000};
      check("stress_occ", occupancy, sb.size());
      check("stress_in_ready", in_ready, (sb.size() < 2));
      check("stress_head", {out_instruction, out_next_pc}, exp_head);
      begin
        bit do_push;
        bit do_pop;
        do_push = v && (sb.size() < 2);
        do_pop  = r && (sb.size() > 0);
        if (f) begin
          sb.delete();
        end else begin
          if (do_pop)  void'(sb.pop_front());
          if (do_push) sb.push_back(nxt);
        end
      end
      step();
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
